// File: rtl/seq_pattern_gen_pkg.sv
// Shared types and helpers for the serial pattern generator.
// Optional feature macro: SEQ_GEN_PARITY_EN (adds a trailing even-parity bit).
package seq_gen_pkg;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        SHIFT = 2'd1,
        PAR   = 2'd2
    } state_t;

    // Level driven on seq_out when no pattern bit is being presented.
    localparam logic SEQ_IDLE_VAL = 1'b0;

    // Lengths above the pattern width are limited to the pattern width.
    function automatic int unsigned clamp_len(input int unsigned len, input int unsigned width);
        return (len > width) ? width : len;
    endfunction

endpackage

// File: rtl/seq_pattern_gen_if.sv
// Command handshake and serial output bundle of seq_pattern_gen.
// Optional feature macro: SEQ_GEN_PARITY_EN (no effect on this bundle).
interface seq_pattern_gen_if #(
    parameter int WIDTH = 8,
    parameter int CNT_W = 4
);
    localparam int LEN_W = $clog2(WIDTH) + 1;

    logic [WIDTH-1:0] pat_in;
    logic [LEN_W-1:0] len_in;
    logic [CNT_W-1:0] rep_in;
    logic             start_valid;
    logic             start_ready;
    logic             seq_out;
    logic             seq_valid;
    logic             busy;
    logic             done;

    // Command source / stream sink side.
    modport master (
        output pat_in, len_in, rep_in, start_valid,
        input  start_ready, seq_out, seq_valid, busy, done
    );

    // Generator side.
    modport slave (
        input  pat_in, len_in, rep_in, start_valid,
        output start_ready, seq_out, seq_valid, busy, done
    );
endinterface

// File: rtl/seq_pattern_gen_shift_reg.sv
// Loadable MSB-first shift register with bit-index counter and running parity.
// Optional feature macro: SEQ_GEN_PARITY_EN (enables the running-parity output).
module seq_shift_reg
    import seq_gen_pkg::*;
#(
    parameter int WIDTH = 8,
    parameter int LEN_W = $clog2(WIDTH) + 1
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             i_load,
    input  logic [WIDTH-1:0] i_pat,
    input  logic [LEN_W-1:0] i_len,
    input  logic             i_reload,
    input  logic             i_shift,
    output logic             o_next_msb,
    output logic             o_last
`ifdef SEQ_GEN_PARITY_EN
    ,
    output logic             o_par
`endif
);

    logic [WIDTH-1:0] r_pat_al;
    logic [WIDTH-1:0] r_sh;
    logic [LEN_W-1:0] r_idx;
    logic [LEN_W-1:0] r_len;
    logic [WIDTH-1:0] w_aligned;
`ifdef SEQ_GEN_PARITY_EN
    logic             r_par;
`endif

    // Left-align the pattern so bit len-1 sits at the MSB; unused low bits fall off.
    always_comb begin
        w_aligned = i_pat << (LEN_W'(WIDTH) - i_len);
    end

    // Bit that will be at the head after this edge's operation.
    always_comb begin
        if (i_load)
            o_next_msb = w_aligned[WIDTH-1];
        else if (i_reload)
            o_next_msb = r_pat_al[WIDTH-1];
        else
            o_next_msb = r_sh[WIDTH-2];
    end

    assign o_last = (r_idx == '0);
`ifdef SEQ_GEN_PARITY_EN
    assign o_par = r_par;
`endif

    // Pattern storage, shifting and index countdown.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            r_pat_al <= '0;
            r_sh     <= '0;
            r_idx    <= '0;
            r_len    <= '0;
`ifdef SEQ_GEN_PARITY_EN
            r_par    <= 1'b0;
`endif
        end else if (i_load) begin
            r_pat_al <= w_aligned;
            r_sh     <= w_aligned;
            r_idx    <= i_len - LEN_W'(1);
            r_len    <= i_len;
`ifdef SEQ_GEN_PARITY_EN
            r_par    <= w_aligned[WIDTH-1];
`endif
        end else if (i_reload) begin
            r_sh     <= r_pat_al;
            r_idx    <= r_len - LEN_W'(1);
`ifdef SEQ_GEN_PARITY_EN
            r_par    <= r_pat_al[WIDTH-1];
`endif
        end else if (i_shift) begin
            r_sh     <= r_sh << 1;
            r_idx    <= r_idx - LEN_W'(1);
`ifdef SEQ_GEN_PARITY_EN
            r_par    <= r_par ^ r_sh[WIDTH-2];
`endif
        end
    end

endmodule

// File: rtl/seq_pattern_gen.sv
// Serial pattern transmitter: sends pat[len-1:0] MSB-first, rep+1 times back-to-back.
// Optional feature macro: SEQ_GEN_PARITY_EN (even-parity bit after each repetition).
module seq_pattern_gen
    import seq_gen_pkg::*;
#(
    parameter int   WIDTH    = 8,
    parameter int   CNT_W    = 4,
    parameter logic IDLE_VAL = SEQ_IDLE_VAL
) (
    input  logic            clk,
    input  logic            reset,
    seq_pattern_gen_if.slave bus
);

    localparam int LEN_W = $clog2(WIDTH) + 1;

    state_t           r_state;
    logic [CNT_W-1:0] r_rep;
    logic             r_seq_out;
    logic             r_seq_valid;
    logic             r_busy;
    logic             r_done;
    logic             r_start_ready;

    logic [LEN_W-1:0] w_len;
    logic             w_accept;
    logic             w_load;
    logic             w_shift;
    logic             w_reload;
    logic             w_next_msb;
    logic             w_last;
`ifdef SEQ_GEN_PARITY_EN
    logic             w_par;
`endif

    assign bus.start_ready = r_start_ready;
    assign bus.seq_out     = r_seq_out;
    assign bus.seq_valid   = r_seq_valid;
    assign bus.busy        = r_busy;
    assign bus.done        = r_done;

    // Command acceptance and shift-register operation select.
    always_comb begin
        w_len    = LEN_W'(clamp_len(32'(bus.len_in), 32'(WIDTH)));
        w_accept = bus.start_valid && r_start_ready;
        w_load   = w_accept && (w_len != '0);
        w_shift  = (r_state == SHIFT) && r_seq_valid && !w_last;
`ifdef SEQ_GEN_PARITY_EN
        w_reload = (r_state == PAR) && (r_rep != '0);
`else
        w_reload = (r_state == SHIFT) && r_seq_valid && w_last && (r_rep != '0);
`endif
    end

    seq_shift_reg #(
        .WIDTH (WIDTH),
        .LEN_W (LEN_W)
    ) u_shift (
        .clk        (clk),
        .reset      (reset),
        .i_load     (w_load),
        .i_pat      (bus.pat_in),
        .i_len      (w_len),
        .i_reload   (w_reload),
        .i_shift    (w_shift),
        .o_next_msb (w_next_msb),
        .o_last     (w_last)
`ifdef SEQ_GEN_PARITY_EN
        ,
        .o_par      (w_par)
`endif
    );

    // Control FSM, repeat counter and registered stream outputs.
    // A zero-length command parks in SHIFT with seq_valid low for one cycle so
    // done follows acceptance by exactly one edge.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            r_state       <= IDLE;
            r_rep         <= '0;
            r_seq_out     <= IDLE_VAL;
            r_seq_valid   <= 1'b0;
            r_busy        <= 1'b0;
            r_done        <= 1'b0;
            r_start_ready <= 1'b1;
        end else begin
            r_done <= 1'b0;
            case (r_state)
                IDLE: begin
                    if (w_accept) begin
                        r_state       <= SHIFT;
                        r_rep         <= bus.rep_in;
                        r_busy        <= 1'b1;
                        r_start_ready <= 1'b0;
                        if (w_load) begin
                            r_seq_out   <= w_next_msb;
                            r_seq_valid <= 1'b1;
                        end
                    end
                end
                SHIFT: begin
                    if (!r_seq_valid) begin
                        r_state       <= IDLE;
                        r_busy        <= 1'b0;
                        r_done        <= 1'b1;
                        r_start_ready <= 1'b1;
                    end else if (!w_last) begin
                        r_seq_out <= w_next_msb;
`ifdef SEQ_GEN_PARITY_EN
                    end else begin
                        r_state   <= PAR;
                        r_seq_out <= w_par;
                    end
`else
                    end else if (r_rep != '0) begin
                        r_rep     <= r_rep - CNT_W'(1);
                        r_seq_out <= w_next_msb;
                    end else begin
                        r_state       <= IDLE;
                        r_seq_out     <= IDLE_VAL;
                        r_seq_valid   <= 1'b0;
                        r_busy        <= 1'b0;
                        r_done        <= 1'b1;
                        r_start_ready <= 1'b1;
                    end
`endif
                end
`ifdef SEQ_GEN_PARITY_EN
                PAR: begin
                    if (r_rep != '0) begin
                        r_state   <= SHIFT;
                        r_rep     <= r_rep - CNT_W'(1);
                        r_seq_out <= w_next_msb;
                    end else begin
                        r_state       <= IDLE;
                        r_seq_out     <= IDLE_VAL;
                        r_seq_valid   <= 1'b0;
                        r_busy        <= 1'b0;
                        r_done        <= 1'b1;
                        r_start_ready <= 1'b1;
                    end
                end
`endif
                default: begin
                    r_state       <= IDLE;
                    r_seq_out     <= IDLE_VAL;
                    r_seq_valid   <= 1'b0;
                    r_busy        <= 1'b0;
                    r_start_ready <= 1'b1;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_seq_pattern_gen.sv
// Scoreboard bench for seq_pattern_gen (WIDTH=8, CNT_W=4, IDLE_VAL=0).
// Optional feature macro: SEQ_GEN_PARITY_EN (expected stream gains parity bits).
module tb_seq_pattern_gen;

    localparam logic IDLE_V = 1'b0;

    logic clk;
    logic reset;
    int   checks;
    int   errors;
    int   cyc;

    // Expected per-cycle observation: {seq_valid, seq_out, busy, done, start_ready}
    logic [4:0] q[$];

    seq_pattern_gen_if #(.WIDTH(8), .CNT_W(4)) bus ();

    seq_pattern_gen #(
        .WIDTH    (8),
        .CNT_W    (4),
        .IDLE_VAL (IDLE_V)
    ) dut (
        .clk   (clk),
        .reset (reset),
        .bus   (bus)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    initial begin
        cyc = 0;
        forever begin
            @(posedge clk);
            cyc++;
        end
    end

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s cyc=%0d actual=%h expected=%h", name, cyc, act, exp);
        end
    endtask

    function automatic logic [4:0] obs();
        return {bus.seq_valid, bus.seq_out, bus.busy, bus.done, bus.start_ready};
    endfunction

    // Monitor: whenever the DUT presents anything, pop and compare.
    initial begin
        forever begin
            @(negedge clk);
            if (reset && (bus.busy || bus.done || bus.seq_valid)) begin
                if (q.size() == 0) begin
                    checks++;
                    errors++;
                    $display("FAIL unexpected cyc=%0d actual=%b expected=nothing", cyc, obs());
                end else begin
                    chk("stream", 32'(obs()), 32'(q.pop_front()));
                end
            end
        end
    end

    // Build expected stream for one command from hand-derived rules.
    task automatic push_cmd(input logic [7:0] pat, input logic [3:0] len, input logic [3:0] rep);
        int unsigned l;
        logic        p;
        l = (len > 8) ? 8 : len;
        if (l == 0) begin
            q.push_back({1'b0, IDLE_V, 1'b1, 1'b0, 1'b0});
        end else begin
            for (int unsigned r = 0; r <= rep; r++) begin
                p = 1'b0;
                for (int i = int'(l) - 1; i >= 0; i--) begin
                    q.push_back({1'b1, pat[i], 1'b1, 1'b0, 1'b0});
                    p = p ^ pat[i];
                end
`ifdef SEQ_GEN_PARITY_EN
                q.push_back({1'b1, p, 1'b1, 1'b0, 1'b0});
`endif
            end
        end
        q.push_back({1'b0, IDLE_V, 1'b0, 1'b1, 1'b1});
    endtask

    task automatic issue(input logic [7:0] pat, input logic [3:0] len, input logic [3:0] rep,
                         input bit keep, output int acc_cyc);
        int w;
        @(negedge clk);
        #1;
        w = 0;
        while (!bus.start_ready && w < 100) begin
            @(negedge clk);
            #1;
            w++;
        end
        if (!bus.start_ready) chk("ready_wait", 32'(bus.start_ready), 32'd1);
        bus.pat_in      = pat;
        bus.len_in      = len;
        bus.rep_in      = rep;
        bus.start_valid = 1'b1;
        push_cmd(pat, len, rep);
        @(posedge clk);
        #1;
        acc_cyc = cyc;
        // Scramble inputs after acceptance; the DUT must ignore them.
        bus.pat_in = ~pat;
        bus.len_in = 4'd1;
        bus.rep_in = 4'd7;
        if (!keep) bus.start_valid = 1'b0;
    endtask

    task automatic drain();
        int w;
        w = 0;
        while (q.size() != 0 && w < 300) begin
            @(negedge clk);
            w++;
        end
        if (q.size() != 0) chk("drain_timeout", 32'(q.size()), 32'd0);
        q.delete();
        repeat (3) @(negedge clk);
    endtask

    initial begin
        int a0, a1, a2;
        checks = 0;
        errors = 0;
        reset  = 1'b0;
        bus.pat_in = '0;
        bus.len_in = '0;
        bus.rep_in = '0;
        bus.start_valid = 1'b0;
        #12;
        chk("reset_state", 32'(obs()), 32'({1'b0, IDLE_V, 1'b0, 1'b0, 1'b1}));
        @(negedge clk);
        reset = 1'b1;
        repeat (2) @(negedge clk);

        // Basic 4-bit pattern 1011
        issue(8'h0B, 4'd4, 4'd0, 1'b0, a0);
        drain();

        // Three back-to-back repetitions of 101
        issue(8'h05, 4'd3, 4'd2, 1'b0, a0);
        drain();

        // Reset during the third bit of an 8-bit command
        q.push_back({1'b1, 1'b1, 1'b1, 1'b0, 1'b0});
        q.push_back({1'b1, 1'b0, 1'b1, 1'b0, 1'b0});
        q.push_back({1'b1, 1'b1, 1'b1, 1'b0, 1'b0});
        bus.pat_in = 8'hA5;
        bus.len_in = 4'd8;
        bus.rep_in = 4'd0;
        @(negedge clk);
        #1;
        bus.start_valid = 1'b1;
        @(posedge clk);
        #1;
        bus.start_valid = 1'b0;
        repeat (3) @(negedge clk);
        #2;
        reset = 1'b0;
        #1;
        chk("async_reset", 32'(obs()), 32'({1'b0, IDLE_V, 1'b0, 1'b0, 1'b1}));
        chk("abort_queue", 32'(q.size()), 32'd0);
        q.delete();
        @(posedge clk);
        @(posedge clk);
        #1;
        reset = 1'b1;
        repeat (4) @(negedge clk);
        issue(8'h3C, 4'd8, 4'd0, 1'b0, a0);
        drain();

        // start_valid held continuously, len=2: accepted every third cycle
        issue(8'h02, 4'd2, 4'd0, 1'b1, a0);
        issue(8'h01, 4'd2, 4'd0, 1'b1, a1);
        issue(8'h03, 4'd2, 4'd0, 1'b0, a2);
`ifdef SEQ_GEN_PARITY_EN
        chk("accept_gap1", 32'(a1 - a0), 32'd4);
        chk("accept_gap2", 32'(a2 - a1), 32'd4);
`else
        chk("accept_gap1", 32'(a1 - a0), 32'd3);
        chk("accept_gap2", 32'(a2 - a1), 32'd3);
`endif
        drain();

        // Zero length: no bits, done one edge after acceptance
        issue(8'hFF, 4'd0, 4'd3, 1'b0, a0);
        drain();

        // Length above WIDTH is clamped to 8
        issue(8'hC3, 4'd12, 4'd0, 1'b0, a0);
        drain();

        // Single-bit pattern repeated twice
        issue(8'h01, 4'd1, 4'd1, 1'b0, a0);
        drain();

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

    // Absolute time bound.
    initial begin
        #200000;
        $display("FAIL global_timeout cyc=%0d actual=running expected=finished", cyc);
        $fatal(1);
    end

endmodule

// File: doc/seq_pattern_gen.md
Name: seq_pattern_gen

Overview:
- Serial pattern transmitter: accepts a parallel bit pattern, length and repeat count over a valid/ready handshake, then drives it MSB-first one bit per clock on seq_out.
- Stimulus/source side of the single-bit serial stream consumed by the sequence detector; drives seq_in of detector instances in system benches and in-design self-test.
- Registered outputs, back-to-back repeats, single-cycle done pulse.

Parameters:
- WIDTH, 8, maximum pattern length in bits (>=2)
- CNT_W, 4, width of repeat count
- IDLE_VAL, 1'b0, seq_out level whenever seq_valid is low
- LEN_W (localparam), $clog2(WIDTH)+1, width of len_in

Ports:
- clk  input  1  system clock, all logic on rising edge
- reset  input  1  asynchronous, active-low reset
- pat_in  input  WIDTH  pattern; bits pat_in[len-1:0] transmitted, bit len-1 first
- len_in  input  LEN_W  number of pattern bits per transmission
- rep_in  input  CNT_W  extra repetitions (0 = send once, N = send N+1 times)
- start_valid  input  1  command request
- start_ready  output  1  high only in IDLE
- seq_out  output  1  serial data bit
- seq_valid  output  1  high while seq_out carries a pattern (or parity) bit
- busy  output  1  high in SHIFT/PAR
- done  output  1  one-cycle pulse at end of command

Behaviour:
- Reset (reset=0, async): state=IDLE, seq_out=IDLE_VAL, seq_valid=0, busy=0, done=0, counters cleared; start_ready=1 once in IDLE. Reset mid-transmission aborts immediately, with no done pulse.
- States: IDLE, SHIFT, PAR (PAR only with the optional feature).
- Accept: rising edge with start_valid && start_ready. pat_in, effective length and rep_in are latched. On that same edge, seq_out <= pat_in[len-1], seq_valid <= 1, busy <= 1, state -> SHIFT. Latency is zero cycles after acceptance.
- SHIFT: each edge presents the next lower bit. The bit counter runs len-1 down to 0.
- After bit 0 with repetitions remaining: the next edge reloads the latched pattern and drives bit len-1 again. There is no gap between repetitions, and the repeat counter decrements.
- After bit 0 of the final repetition: the next edge sets state=IDLE, seq_valid=0, seq_out=IDLE_VAL, busy=0 and done=1 for exactly one cycle.
- start_valid is ignored while busy. A new command may be accepted in the done cycle, which gives exactly one idle bit between commands.
- len_in > WIDTH: clamped to WIDTH.
- len_in = 0: command is accepted, no bits are sent, seq_valid stays 0, and done pulses on the next edge.
- Inputs pat_in, len_in and rep_in are don't-care after acceptance; changes have no effect.

Optional Feature:
- Macro SEQ_GEN_PARITY_EN.
- Defined: after bit 0 of every repetition, state goes to PAR for one cycle. seq_out = even parity (XOR of the len transmitted bits), seq_valid=1. PAR then proceeds to the next repetition or to the end sequence as SHIFT does.
- len=0 with the feature defined: still no bits and no parity bit.
- Undefined: PAR state and parity logic are absent; timing is exactly as in Behaviour.

Decomposition:
- Package seq_gen_pkg holds:
  - state_t enum (IDLE, SHIFT, PAR)
  - function clamp_len(len, WIDTH)
  - IDLE_VAL default constant
- One natural sub-module: seq_shift_reg, a loadable WIDTH-bit MSB-first shift register with bit-index counter and running-parity output.
- The FSM and repeat counter live in the top module.

Test Plan:
- pat_in=8'h0B, len_in=4, rep_in=0 -> seq_out 1,0,1,1 with seq_valid high for 4 cycles; done pulses on the 5th edge; detector downstream fires once.
- pat_in=8'h05, len_in=3, rep_in=2 -> seq_out 1,0,1,1,0,1,1,0,1 contiguous for 9 cycles, then one done pulse.
- Assert reset=0 on the 3rd bit of a len=8 command -> all outputs reach reset values without waiting for a clock edge; no done pulse; the next command runs normally.
- start_valid held high continuously with len=2, rep=0 -> commands accepted every 3 cycles (2 bits plus one idle); start_ready low while busy.
- len_in=0 -> seq_valid never rises, done pulses one cycle after acceptance.
- len_in=12 with WIDTH=8 -> 8 bits sent, matching pat_in[7:0].
- With SEQ_GEN_PARITY_EN, pat_in=8'h0B, len=4 -> seq_out 1,0,1,1,1 (parity 1), 5 valid cycles.
